// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory completer.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   // Wait counter width; a zero-wait slave still keeps one bit.
   function automatic int unsigned cnt_width(input int unsigned wait_cycles);
      if (wait_cycles == 0) return 1;
      return $clog2(wait_cycles + 1);
   endfunction

   function automatic int unsigned idx_width(input int unsigned depth);
      if (depth <= 1) return 1;
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register file: synchronous clear, one write port, combinational read.
module apb_regfile
   import apb_pkg::*;
#(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned DATA_W = APB_DATA_W
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           we_i,
   input  logic [idx_width(DEPTH)-1:0]    waddr_i,
   input  logic [DATA_W-1:0]              wdata_i,
   input  logic [idx_width(DEPTH)-1:0]    raddr_i,
   output logic [DATA_W-1:0]              rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Reset has priority so an in-flight write is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q <= '{default: '0};
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB3 completer serving an 8-bit register file with programmable wait states,
// out-of-range error response and a sticky requester-sequencing error flag.
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned ADDR_W      = APB_ADDR_W,
   parameter int unsigned DATA_W      = APB_DATA_W
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              proto_err
);

   localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);
   localparam int unsigned IDX_W = idx_width(DEPTH);

   apb_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic              pready_q;
   logic              pslverr_q;
   logic [DATA_W-1:0] prdata_q;
   logic              proto_err_q;

   logic [CNT_W-1:0]  cnt_inc_c;
   logic [DATA_W-1:0] rd_data_c;
   logic [DATA_W-1:0] resp_data_c;
   logic              resp_err_c;
   logic              in_range_c;
   logic              done_c;
   logic              start_c;
   logic              mismatch_c;
   logic              we_c;
   logic              issue_c;
   logic              proto_viol_c;

   assign in_range_c  = (addr_q < ADDR_W'(DEPTH));
   assign cnt_inc_c   = cnt_q + CNT_W'(1);
   assign done_c      = (state_q == ACCESS) && (cnt_q == CNT_W'(WAIT_CYCLES));
   assign start_c     = psel && !penable;
   assign mismatch_c  = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);
   assign we_c        = done_c && write_q && in_range_c;
   assign resp_err_c  = in_range_c ? RESP_OKAY : RESP_SLVERR;
   assign resp_data_c = (!write_q && in_range_c) ? rd_data_c : '0;

   // issue_c: the coming edge opens the pready cycle. The completion cycle itself is
   // exempt from sequencing checks so a requester may present its next setup there.
   always_comb begin
      issue_c      = 1'b0;
      proto_viol_c = 1'b0;
      case (state_q)
         IDLE: begin
            proto_viol_c = psel && penable;
         end
         SETUP: begin
            proto_viol_c = !psel || mismatch_c;
            issue_c      = psel && (WAIT_CYCLES == 0);
         end
         ACCESS: begin
            proto_viol_c = !done_c && (!psel || !penable || mismatch_c);
            issue_c      = !done_c && psel && (cnt_inc_c == CNT_W'(WAIT_CYCLES));
         end
         default: begin
            proto_viol_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         pready_q  <= issue_c;
         pslverr_q <= issue_c ? resp_err_c : 1'b0;
         prdata_q  <= issue_c ? resp_data_c : '0;
         if (proto_viol_c) proto_err_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (start_c) begin
                  state_q <= SETUP;
                  addr_q  <= paddr;
                  write_q <= pwrite;
                  wdata_q <= pwdata;
               end
            end
            SETUP: begin
               cnt_q   <= '0;
               state_q <= psel ? ACCESS : IDLE;
            end
            ACCESS: begin
               if (done_c) begin
                  if (start_c) begin
                     state_q <= SETUP;
                     addr_q  <= paddr;
                     write_q <= pwrite;
                     wdata_q <= pwdata;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (!psel) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_inc_c;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   apb_regfile #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk_i   (pclk),
      .rst_i   (prst),
      .we_i    (we_c),
      .waddr_i (addr_q[IDX_W-1:0]),
      .wdata_i (wdata_q),
      .raddr_i (addr_q[IDX_W-1:0]),
      .rdata_o (rd_data_c)
   );

   assign prdata    = prdata_q;
   assign pready    = pready_q;
   assign pslverr   = pslverr_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: a zero-wait and a two-wait instance share the bus, each with its own psel.
module tb_apb_mem_slave;

   localparam bit D0 = 1'b0;
   localparam bit D2 = 1'b1;

   logic        pclk = 1'b0;
   logic        prst;
   logic        psel0, psel2, penable, pwrite;
   logic [31:0] paddr;
   logic [7:0]  pwdata;
   logic [7:0]  prdata0, prdata2;
   logic        pready0, pready2, pslverr0, pslverr2, perr0, perr2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 pclk = ~pclk;

   apb_mem_slave #(.DEPTH(32), .WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(8)) u_dut0 (
      .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
      .pslverr(pslverr0), .proto_err(perr0)
   );

   apb_mem_slave #(.DEPTH(32), .WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(8)) u_dut2 (
      .pclk(pclk), .prst(prst), .psel(psel2), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata2), .pready(pready2),
      .pslverr(pslverr2), .proto_err(perr2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete transfer; lat counts cycles from the slave's SETUP cycle to pready.
   task automatic apb_xfer(input bit sel, input bit wr, input logic [31:0] addr,
                           input logic [7:0] wdata, input bit corrupt,
                           output logic [7:0] rdata, output logic err, output int lat);
      @(posedge pclk); #1;
      if (sel) psel2 = 1'b1; else psel0 = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(posedge pclk); #1;
      penable = 1'b1;
      if (corrupt) begin
         paddr  = addr + 32'd1;
         pwdata = ~wdata;
      end
      lat = 0;
      @(negedge pclk);
      while (!(sel ? pready2 : pready0) && lat < 20) begin
         @(negedge pclk);
         lat++;
      end
      rdata = sel ? prdata2 : prdata0;
      err   = sel ? pslverr2 : pslverr0;
      @(posedge pclk); #1;
      psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("ready_one_cycle", 32'(sel ? pready2 : pready0), 32'd0);
      check("prdata_idle_zero", 32'(sel ? prdata2 : prdata0), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;
      logic       er;
      int         lat;
      int         seen;

      prst = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      repeat (3) @(posedge pclk);
      #1 prst = 1'b0;
      @(negedge pclk);
      check("rst_pready0", 32'(pready0), 32'd0);
      check("rst_pslverr0", 32'(pslverr0), 32'd0);
      check("rst_prdata0", 32'(prdata0), 32'd0);
      check("rst_perr0", 32'(perr0), 32'd0);
      check("rst_pready2", 32'(pready2), 32'd0);
      check("rst_perr2", 32'(perr2), 32'd0);

      // Zero-wait write then read
      apb_xfer(D0, 1'b1, 32'h04, 8'hA5, 1'b0, rd, er, lat);
      check("t1_wr_lat", 32'(lat), 32'd1);
      check("t1_wr_err", 32'(er), 32'd0);
      apb_xfer(D0, 1'b0, 32'h04, 8'h00, 1'b0, rd, er, lat);
      check("t1_rd_lat", 32'(lat), 32'd1);
      check("t1_rd_data", 32'(rd), 32'hA5);
      check("t1_rd_err", 32'(er), 32'd0);

      // Out-of-range accesses
      apb_xfer(D0, 1'b1, 32'h20, 8'h3C, 1'b0, rd, er, lat);
      check("t3_oor_wr_err", 32'(er), 32'd1);
      check("t3_oor_wr_lat", 32'(lat), 32'd1);
      apb_xfer(D0, 1'b0, 32'h00, 8'h00, 1'b0, rd, er, lat);
      check("t3_rd0_data", 32'(rd), 32'h00);
      check("t3_rd0_err", 32'(er), 32'd0);
      apb_xfer(D0, 1'b0, 32'h20, 8'h00, 1'b0, rd, er, lat);
      check("t3_oor_rd_data", 32'(rd), 32'h00);
      check("t3_oor_rd_err", 32'(er), 32'd1);
      apb_xfer(D0, 1'b1, 32'h8000_0004, 8'hEE, 1'b0, rd, er, lat);
      check("t3_hi_wr_err", 32'(er), 32'd1);
      apb_xfer(D0, 1'b0, 32'h04, 8'h00, 1'b0, rd, er, lat);
      check("t3_no_alias", 32'(rd), 32'hA5);

      // Back-to-back write/read with psel held high
      @(posedge pclk); #1;
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h01; pwdata = 8'h11;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk);
      check("t4_setup_noready", 32'(pready0), 32'd0);
      @(posedge pclk); #1;
      penable = 1'b0; pwrite = 1'b0;
      @(negedge pclk);
      check("t4_wr_ready", 32'(pready0), 32'd1);
      check("t4_wr_err", 32'(pslverr0), 32'd0);
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk);
      check("t4_second_setup", 32'(pready0), 32'd0);
      @(negedge pclk);
      check("t4_rd_ready", 32'(pready0), 32'd1);
      check("t4_rd_data", 32'(prdata0), 32'h11);
      @(posedge pclk); #1;
      psel0 = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("t4_rd_one_cycle", 32'(pready0), 32'd0);
      check("t4_no_proto_err", 32'(perr0), 32'd0);

      // Two-wait read after reset, then write/readback
      apb_xfer(D2, 1'b0, 32'h1F, 8'h00, 1'b0, rd, er, lat);
      check("t2_rd_lat", 32'(lat), 32'd3);
      check("t2_rd_data", 32'(rd), 32'h00);
      check("t2_rd_err", 32'(er), 32'd0);
      apb_xfer(D2, 1'b1, 32'h1F, 8'h5A, 1'b0, rd, er, lat);
      check("t2_wr_lat", 32'(lat), 32'd3);
      apb_xfer(D2, 1'b0, 32'h1F, 8'h00, 1'b0, rd, er, lat);
      check("t2_rdback", 32'(rd), 32'h5A);
      check("t2_no_proto_err", 32'(perr2), 32'd0);

      // psel dropped during ACCESS of a two-wait write
      @(posedge pclk); #1;
      psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h02; pwdata = 8'h77;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1;
      psel2 = 1'b0; penable = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge pclk);
         if (pready2) seen++;
      end
      check("t5_no_ready", 32'(seen), 32'd0);
      check("t5_proto_err", 32'(perr2), 32'd1);
      apb_xfer(D2, 1'b0, 32'h02, 8'h00, 1'b0, rd, er, lat);
      check("t5_no_write", 32'(rd), 32'h00);
      check("t5_recover_lat", 32'(lat), 32'd3);

      // Captured values win when the bus changes under a transfer
      apb_xfer(D0, 1'b1, 32'h05, 8'h66, 1'b1, rd, er, lat);
      check("cap_err", 32'(er), 32'd0);
      check("cap_proto_err", 32'(perr0), 32'd1);
      apb_xfer(D0, 1'b0, 32'h05, 8'h00, 1'b0, rd, er, lat);
      check("cap_rd5", 32'(rd), 32'h66);
      apb_xfer(D0, 1'b0, 32'h06, 8'h00, 1'b0, rd, er, lat);
      check("cap_rd6", 32'(rd), 32'h00);

      // Reset during ACCESS of a two-wait write
      @(posedge pclk); #1;
      psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h03; pwdata = 8'h55;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 prst = 1'b1;
      @(posedge pclk); #1;
      prst = 1'b0; psel2 = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("t6_pready", 32'(pready2), 32'd0);
      check("t6_pslverr", 32'(pslverr2), 32'd0);
      check("t6_prdata", 32'(prdata2), 32'd0);
      check("t6_perr2", 32'(perr2), 32'd0);
      check("t6_perr0", 32'(perr0), 32'd0);
      apb_xfer(D2, 1'b0, 32'h03, 8'h00, 1'b0, rd, er, lat);
      check("t6_no_write", 32'(rd), 32'h00);
      apb_xfer(D2, 1'b0, 32'h1F, 8'h00, 1'b0, rd, er, lat);
      check("t6_mem_cleared2", 32'(rd), 32'h00);

      // psel with penable in IDLE: flagged, no transfer started
      @(posedge pclk); #1;
      psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h04;
      @(posedge pclk); #1;
      psel0 = 1'b0; penable = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge pclk);
         if (pready0) seen++;
      end
      check("idle_viol_no_ready", 32'(seen), 32'd0);
      check("idle_viol_proto_err", 32'(perr0), 32'd1);
      apb_xfer(D0, 1'b0, 32'h04, 8'h00, 1'b0, rd, er, lat);
      check("mem_cleared0", 32'(rd), 32'h00);
      check("post_viol_lat", 32'(lat), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
